iob_cache_be_arbiter: RTL and testbench



---
 rtl/iob_cache_be_arbiter_pkg.sv | 15 +
 rtl/iob_cache_be_arbiter_mux.sv | 50 +++++
 rtl/iob_cache_be_arbiter.sv | 118 +++++++++++
 tb/tb_iob_cache_be_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_cache_be_arbiter_pkg.sv
// Shared definitions for the cache back-end arbiter: grant state encodings
// and default geometry of the native back-end port.
package iob_cache_be_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_W = 2'd1,
        ARB_GRANT_R = 2'd2
    } arb_state_t;

    localparam int ARB_BE_ADDR_W_DEFAULT = 24;
    localparam int ARB_BE_DATA_W_DEFAULT = 32;
    localparam int ARB_WR_MAX_DEFAULT    = 4;

endpackage

// File: rtl/iob_cache_be_arbiter_mux.sv
// Combinational back-end steering: selects the granted requester's request
// onto the back-end port and routes the back-end ack back to it.
module iob_cache_be_arbiter_mux
    import iob_cache_be_arbiter_pkg::*;
#(
    parameter int BE_ADDR_W = ARB_BE_ADDR_W_DEFAULT,
    parameter int BE_DATA_W = ARB_BE_DATA_W_DEFAULT
) (
    input  arb_state_t               state,
    input  logic                     rd_valid,
    input  logic [BE_ADDR_W-1:0]     rd_addr,
    input  logic                     wr_valid,
    input  logic [BE_ADDR_W-1:0]     wr_addr,
    input  logic [BE_DATA_W-1:0]     wr_wdata,
    input  logic [BE_DATA_W/8-1:0]   wr_wstrb,
    input  logic                     be_ack,
    output logic                     be_valid,
    output logic [BE_ADDR_W-1:0]     be_addr,
    output logic [BE_DATA_W-1:0]     be_wdata,
    output logic [BE_DATA_W/8-1:0]   be_wstrb,
    output logic                     rd_ack,
    output logic                     wr_ack
);

    // An ack only counts while the granted requester is actually asking.
    always_comb begin
        be_valid = 1'b0;
        be_addr  = '0;
        be_wdata = '0;
        be_wstrb = '0;
        rd_ack   = 1'b0;
        wr_ack   = 1'b0;
        case (state)
            ARB_GRANT_W: begin
                be_valid = wr_valid;
                be_addr  = wr_addr;
                be_wdata = wr_wdata;
                be_wstrb = wr_wstrb;
                wr_ack   = wr_valid & be_ack;
            end
            ARB_GRANT_R: begin
                be_valid = rd_valid;
                be_addr  = rd_addr;
                rd_ack   = rd_valid & be_ack;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/iob_cache_be_arbiter.sv
// Back-end port arbiter between the line-fill read channel and the
// write-through buffer: write priority, read burst lock, write starvation cap.
//
//   state   | meaning
//   IDLE    | no grant, back-end port driven to zero
//   GRANT_W | write-through buffer owns the port
//   GRANT_R | line-fill channel owns the port (held by rd_lock_i)
module iob_cache_be_arbiter
    import iob_cache_be_arbiter_pkg::*;
#(
    parameter int BE_ADDR_W = ARB_BE_ADDR_W_DEFAULT,
    parameter int BE_DATA_W = ARB_BE_DATA_W_DEFAULT,
    parameter int WR_MAX    = ARB_WR_MAX_DEFAULT,
    parameter int CNT_W     = $clog2(WR_MAX + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     rd_valid_i,
    input  logic [BE_ADDR_W-1:0]     rd_addr_i,
    input  logic                     rd_lock_i,
    output logic                     rd_ack_o,
    output logic [BE_DATA_W-1:0]     rd_rdata_o,
    input  logic                     wr_valid_i,
    input  logic [BE_ADDR_W-1:0]     wr_addr_i,
    input  logic [BE_DATA_W-1:0]     wr_wdata_i,
    input  logic [BE_DATA_W/8-1:0]   wr_wstrb_i,
    output logic                     wr_ack_o,
    output logic                     be_valid_o,
    output logic [BE_ADDR_W-1:0]     be_addr_o,
    output logic [BE_DATA_W-1:0]     be_wdata_o,
    output logic [BE_DATA_W/8-1:0]   be_wstrb_o,
    input  logic                     be_ack_i,
    input  logic [BE_DATA_W-1:0]     be_rdata_i,
    output logic [1:0]               grant_o
);

    arb_state_t       state;
    logic [CNT_W-1:0] wr_cnt;
    logic             wr_done;
    logic             wr_cnt_last;

    assign wr_done     = wr_valid_i & be_ack_i;
    assign wr_cnt_last = (wr_cnt >= CNT_W'(WR_MAX - 1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state  <= ARB_IDLE;
            wr_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (!rd_valid_i) wr_cnt <= '0;
                    if (wr_valid_i) begin
                        state <= ARB_GRANT_W;
                    end else if (rd_valid_i) begin
                        state  <= ARB_GRANT_R;
                        wr_cnt <= '0;
                    end
                end
                ARB_GRANT_W: begin
                    if (!rd_valid_i) wr_cnt <= '0;
                    // Only an accepted write may hand the port to a waiting read.
                    if (wr_done) begin
                        if (rd_valid_i) begin
                            if (wr_cnt_last) begin
                                state  <= ARB_GRANT_R;
                                wr_cnt <= '0;
                            end else if (wr_cnt != CNT_W'(WR_MAX)) begin
                                wr_cnt <= wr_cnt + CNT_W'(1);
                            end
                        end
                    end else if (!wr_valid_i) begin
                        if (rd_valid_i) begin
                            state  <= ARB_GRANT_R;
                            wr_cnt <= '0;
                        end else begin
                            state <= ARB_IDLE;
                        end
                    end
                end
                ARB_GRANT_R: begin
                    // rd_lock_i keeps the grant across the channel's post-burst gap.
                    if (!rd_valid_i && !rd_lock_i) begin
                        state <= wr_valid_i ? ARB_GRANT_W : ARB_IDLE;
                    end
                end
                default: begin
                    state  <= ARB_IDLE;
                    wr_cnt <= '0;
                end
            endcase
        end
    end

    iob_cache_be_arbiter_mux #(
        .BE_ADDR_W (BE_ADDR_W),
        .BE_DATA_W (BE_DATA_W)
    ) u_mux (
        .state     (state),
        .rd_valid  (rd_valid_i),
        .rd_addr   (rd_addr_i),
        .wr_valid  (wr_valid_i),
        .wr_addr   (wr_addr_i),
        .wr_wdata  (wr_wdata_i),
        .wr_wstrb  (wr_wstrb_i),
        .be_ack    (be_ack_i),
        .be_valid  (be_valid_o),
        .be_addr   (be_addr_o),
        .be_wdata  (be_wdata_o),
        .be_wstrb  (be_wstrb_o),
        .rd_ack    (rd_ack_o),
        .wr_ack    (wr_ack_o)
    );

    assign rd_rdata_o = be_rdata_i;
    assign grant_o    = state;

endmodule

// File: tb/tb_iob_cache_be_arbiter.sv
// Self-checking bench for iob_cache_be_arbiter: directed scenarios followed by
// randomized protocol-following requesters, all against an ownership model.
module tb_iob_cache_be_arbiter;

    localparam int BE_ADDR_W = 24;
    localparam int BE_DATA_W = 32;
    localparam int STRB_W    = BE_DATA_W / 8;
    localparam int WR_MAX    = 4;

    logic                   clk_i = 1'b0;
    logic                   reset_i;
    logic                   rd_valid_i;
    logic [BE_ADDR_W-1:0]   rd_addr_i;
    logic                   rd_lock_i;
    logic                   rd_ack_o;
    logic [BE_DATA_W-1:0]   rd_rdata_o;
    logic                   wr_valid_i;
    logic [BE_ADDR_W-1:0]   wr_addr_i;
    logic [BE_DATA_W-1:0]   wr_wdata_i;
    logic [STRB_W-1:0]      wr_wstrb_i;
    logic                   wr_ack_o;
    logic                   be_valid_o;
    logic [BE_ADDR_W-1:0]   be_addr_o;
    logic [BE_DATA_W-1:0]   be_wdata_o;
    logic [STRB_W-1:0]      be_wstrb_o;
    logic                   be_ack_i;
    logic [BE_DATA_W-1:0]   be_rdata_i;
    logic [1:0]             grant_o;

    iob_cache_be_arbiter #(
        .BE_ADDR_W (BE_ADDR_W),
        .BE_DATA_W (BE_DATA_W),
        .WR_MAX    (WR_MAX)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .rd_valid_i (rd_valid_i),
        .rd_addr_i  (rd_addr_i),
        .rd_lock_i  (rd_lock_i),
        .rd_ack_o   (rd_ack_o),
        .rd_rdata_o (rd_rdata_o),
        .wr_valid_i (wr_valid_i),
        .wr_addr_i  (wr_addr_i),
        .wr_wdata_i (wr_wdata_i),
        .wr_wstrb_i (wr_wstrb_i),
        .wr_ack_o   (wr_ack_o),
        .be_valid_o (be_valid_o),
        .be_addr_o  (be_addr_o),
        .be_wdata_o (be_wdata_o),
        .be_wstrb_o (be_wstrb_o),
        .be_ack_i   (be_ack_i),
        .be_rdata_i (be_rdata_i),
        .grant_o    (grant_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Model: who owns the port (0 nobody, 1 write buffer, 2 line fill) and how
    // many writes have been served back to back while a read was waiting.
    int m_owner  = 0;
    int m_streak = 0;

    logic e_rd_ack, e_wr_ack;
    logic obs_rd_ack, obs_wr_ack, obs_be_valid;
    logic [1:0] obs_grant;
    logic [BE_ADDR_W-1:0] obs_addr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic                 e_valid;
        logic [BE_ADDR_W-1:0] e_addr;
        logic [BE_DATA_W-1:0] e_wdata;
        logic [STRB_W-1:0]    e_wstrb;
        e_valid = 1'b0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
        e_rd_ack = 1'b0; e_wr_ack = 1'b0;
        if (m_owner == 1) begin
            e_valid  = wr_valid_i;
            e_addr   = wr_addr_i;
            e_wdata  = wr_wdata_i;
            e_wstrb  = wr_wstrb_i;
            e_wr_ack = wr_valid_i & be_ack_i;
        end else if (m_owner == 2) begin
            e_valid  = rd_valid_i;
            e_addr   = rd_addr_i;
            e_rd_ack = rd_valid_i & be_ack_i;
        end
        check("grant",    64'(grant_o),    64'(m_owner));
        check("be_valid", 64'(be_valid_o), 64'(e_valid));
        check("be_addr",  64'(be_addr_o),  64'(e_addr));
        check("be_wdata", 64'(be_wdata_o), 64'(e_wdata));
        check("be_wstrb", 64'(be_wstrb_o), 64'(e_wstrb));
        check("rd_ack",   64'(rd_ack_o),   64'(e_rd_ack));
        check("wr_ack",   64'(wr_ack_o),   64'(e_wr_ack));
        check("rd_rdata", 64'(rd_rdata_o), 64'(be_rdata_i));
        obs_rd_ack   = rd_ack_o;
        obs_wr_ack   = wr_ack_o;
        obs_be_valid = be_valid_o;
        obs_grant    = grant_o;
        obs_addr     = be_addr_o;
    endtask

    task automatic model_step();
        if (!rd_valid_i) m_streak = 0;
        case (m_owner)
            0: begin
                if (wr_valid_i) m_owner = 1;
                else if (rd_valid_i) m_owner = 2;
            end
            1: begin
                if (wr_valid_i && be_ack_i) begin
                    if (rd_valid_i) begin
                        m_streak++;
                        if (m_streak >= WR_MAX) begin
                            m_owner  = 2;
                            m_streak = 0;
                        end
                    end
                end else if (!wr_valid_i) begin
                    m_owner  = rd_valid_i ? 2 : 0;
                    m_streak = 0;
                end
            end
            default: begin
                if (!rd_valid_i && !rd_lock_i) m_owner = wr_valid_i ? 1 : 0;
            end
        endcase
    endtask

    // Inputs are set at posedge+1; outputs are compared at posedge+4.
    task automatic tick();
        #3;
        check_outputs();
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic go_idle();
        rd_valid_i = 1'b0; rd_lock_i = 1'b0; wr_valid_i = 1'b0; be_ack_i = 1'b0;
        repeat (3) tick();
    endtask

    int  cnt;
    bit  reached;
    int  rd_beats;
    bit  rd_gap;

    initial begin
        reset_i    = 1'b1;
        rd_valid_i = 1'b0; rd_addr_i = '0; rd_lock_i = 1'b0;
        wr_valid_i = 1'b1; wr_addr_i = 24'h000ABC; wr_wdata_i = 32'hCAFE_F00D; wr_wstrb_i = 4'hF;
        be_ack_i   = 1'b1; be_rdata_i = 32'h1234_5678;

        // Reset state: outputs held at zero despite active requests.
        #12;
        check_outputs();
        wr_valid_i = 1'b0; be_ack_i = 1'b0;
        @(posedge clk_i); #1;
        reset_i = 1'b0;

        // Write priority over a simultaneous read.
        wr_valid_i = 1'b1; wr_addr_i = 24'h000100; wr_wdata_i = 32'hA5A5_0001; wr_wstrb_i = 4'hF;
        rd_valid_i = 1'b1; rd_addr_i = 24'h000040;
        tick();
        be_ack_i = 1'b1;
        tick();
        check("prio_valid", 64'(obs_be_valid), 64'd1);
        check("prio_addr",  64'(obs_addr),     64'h100);
        check("prio_wack",  64'(obs_wr_ack),   64'd1);
        check("prio_rack",  64'(obs_rd_ack),   64'd0);
        wr_valid_i = 1'b0; be_ack_i = 1'b0;
        tick();
        be_ack_i = 1'b1;
        tick();
        go_idle();

        // Read burst lock: a write arriving mid-burst waits for the lock to drop.
        cnt = 0;
        rd_valid_i = 1'b1; rd_lock_i = 1'b1; rd_addr_i = 24'h000040;
        tick();
        for (int b = 0; b < 4; b++) begin
            rd_addr_i  = 24'h000040 + BE_ADDR_W'(4 * b);
            be_ack_i   = 1'b1;
            be_rdata_i = $urandom;
            if (b == 2) begin
                wr_valid_i = 1'b1; wr_addr_i = 24'h000200; wr_wdata_i = 32'h0BAD_BEEF; wr_wstrb_i = 4'h3;
            end
            tick();
            if (obs_rd_ack) cnt++;
        end
        rd_valid_i = 1'b0; be_ack_i = 1'b0;
        tick();
        check("lock_gap_grant", 64'(obs_grant), 64'd2);
        rd_lock_i = 1'b0;
        tick();
        be_ack_i = 1'b1;
        tick();
        check("lock_rd_beats",  64'(cnt),        64'd4);
        check("lock_wr_grant",  64'(obs_grant),  64'd1);
        check("lock_wr_ack",    64'(obs_wr_ack), 64'd1);
        go_idle();

        // Write starvation cap, twice in a row to show the streak restarts.
        wr_valid_i = 1'b1; wr_addr_i = 24'h000300; wr_wdata_i = 32'h1111_2222; wr_wstrb_i = 4'h1;
        be_ack_i = 1'b1;
        repeat (3) tick();
        for (int r = 0; r < 2; r++) begin
            rd_valid_i = 1'b1; rd_addr_i = 24'h000080;
            cnt = 0; reached = 1'b0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (obs_grant == 2'd2) begin
                    reached = 1'b1;
                    break;
                end
                if (obs_wr_ack) cnt++;
            end
            check("stv_reach",   64'(reached), 64'd1);
            check("stv_wr_acks", 64'(cnt),     64'd4);
            rd_valid_i = 1'b0;
            tick();
        end
        go_idle();

        // Back-pressure: stalled write keeps the grant and a stable request.
        wr_valid_i = 1'b1; wr_addr_i = 24'h0003A5; wr_wdata_i = 32'hDEAD_0042; wr_wstrb_i = 4'hC;
        rd_valid_i = 1'b1; rd_addr_i = 24'h000080;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_grant", 64'(obs_grant), 64'd1);
            check("bp_addr",  64'(obs_addr),  64'h3A5);
        end
        be_ack_i = 1'b1;
        tick();
        wr_valid_i = 1'b0; be_ack_i = 1'b0;
        tick();
        be_ack_i = 1'b1;
        tick();
        go_idle();

        // Spurious back-end ack in IDLE.
        be_ack_i = 1'b1;
        repeat (2) begin
            tick();
            check("spur_grant", 64'(obs_grant),  64'd0);
            check("spur_acks",  64'({obs_rd_ack, obs_wr_ack}), 64'd0);
        end
        be_ack_i = 1'b0;

        // Reset in the middle of a read burst.
        rd_valid_i = 1'b1; rd_lock_i = 1'b1; rd_addr_i = 24'h000040;
        tick();
        be_ack_i = 1'b1;
        tick();
        rd_addr_i = 24'h000044;
        tick();
        rd_addr_i = 24'h000048;
        #2;
        reset_i = 1'b1;
        m_owner = 0; m_streak = 0;
        #1;
        check_outputs();
        check("rst_be_valid", 64'(be_valid_o), 64'd0);
        rd_valid_i = 1'b0; rd_lock_i = 1'b0; be_ack_i = 1'b0;
        @(posedge clk_i); #1;
        check_outputs();
        reset_i = 1'b0;
        rd_valid_i = 1'b1; rd_addr_i = 24'h000080;
        tick();
        tick();
        check("rst_regrant", 64'(obs_be_valid), 64'd1);
        rd_valid_i = 1'b0;
        go_idle();

        // Randomized requesters obeying the hold-until-ack rule.
        rd_beats = 0; rd_gap = 1'b0;
        for (int n = 0; n < 600; n++) begin
            be_ack_i   = ($urandom_range(0, 3) != 0);
            be_rdata_i = $urandom;
            tick();
            if (e_wr_ack) wr_valid_i = 1'b0;
            if (!wr_valid_i && $urandom_range(0, 2) == 0) begin
                wr_valid_i = 1'b1;
                wr_addr_i  = BE_ADDR_W'($urandom);
                wr_wdata_i = $urandom;
                wr_wstrb_i = STRB_W'($urandom_range(1, 15));
            end
            if (rd_gap) begin
                rd_lock_i = 1'b0;
                rd_gap    = 1'b0;
            end else if (e_rd_ack) begin
                rd_beats--;
                if (rd_beats == 0) begin
                    rd_valid_i = 1'b0;
                    rd_gap     = 1'b1;
                end else begin
                    rd_addr_i = rd_addr_i + BE_ADDR_W'(4);
                end
            end else if (!rd_valid_i && !rd_lock_i && $urandom_range(0, 4) == 0) begin
                rd_beats   = $urandom_range(1, 4);
                rd_valid_i = 1'b1;
                rd_lock_i  = 1'b1;
                rd_addr_i  = BE_ADDR_W'($urandom) & ~BE_ADDR_W'(15);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
